// File: rtl/ex_mem_reg.sv
// ex_mem_reg: execute -> memory pipeline register.
// Captures execute-stage results and precomputes load/store byte lanes.
// Supports stall and flush. Misaligned halfword/word accesses are dropped
// as bubbles, and the drop raises a one-cycle trap pulse.
module ex_mem_reg #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold_i,
   input  logic        flush_i,
   input  logic        valid_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic [31:0] alu_res_i,
   input  logic [31:0] reg_wdata_i,
   input  logic        reg_we_i,
   input  logic [4:0]  reg_waddr_i,
   input  logic [31:0] reg2_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] op1_add_op2_res_o,
   output logic [31:0] reg_wdata_o,
   output logic [31:0] reg2_rdata_o,
   output logic        reg_we_o,
   output logic [4:0]  reg_waddr_o,
   output logic [1:0]  mem_raddr_index_o,
   output logic [1:0]  mem_waddr_index_o,
   output logic        valid_o,
   output logic        misalign_o,
   output logic [31:0] misalign_addr_o,
   output logic [31:0] misalign_pc_o
);

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ACT_CAPTURE,
      ACT_FLUSH,
      ACT_HOLD,
      ACT_TRAP
   } act_e;

   logic [31:0] r_inst;
   logic [31:0] r_inst_addr;
   logic [31:0] r_alu_res;
   logic [31:0] r_reg_wdata;
   logic [31:0] r_reg2_rdata;
   logic        r_reg_we;
   logic [4:0]  r_reg_waddr;
   logic [1:0]  r_raddr_index;
   logic [1:0]  r_waddr_index;
   logic        r_valid;
   logic        r_misalign;
   logic [31:0] r_misalign_addr;
   logic [31:0] r_misalign_pc;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_half;
   logic        w_is_word;
   logic        w_misalign;
   act_e        w_act;

   // Decode the incoming access and pick the edge action by priority.
   always_comb begin
      w_is_load  = (inst_i[6:0] == OPC_LOAD);
      w_is_store = (inst_i[6:0] == OPC_STORE);
      w_is_half  = (w_is_load  && (inst_i[14:12] == 3'b001 || inst_i[14:12] == 3'b101)) ||
                   (w_is_store && (inst_i[14:12] == 3'b001));
      w_is_word  = (w_is_load || w_is_store) && (inst_i[14:12] == 3'b010);
      w_misalign = valid_i && ((w_is_half && alu_res_i[0]) ||
                               (w_is_word && (alu_res_i[1:0] != 2'b00)));
      if (flush_i)         w_act = ACT_FLUSH;
      else if (hold_i)     w_act = ACT_HOLD;
      else if (w_misalign) w_act = ACT_TRAP;
      else                 w_act = ACT_CAPTURE;
   end

   // Pipeline state: bubble by default, overridden by capture or trap; hold keeps all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inst          <= NOP_INST;
         r_inst_addr     <= '0;
         r_alu_res       <= '0;
         r_reg_wdata     <= '0;
         r_reg2_rdata    <= '0;
         r_reg_we        <= 1'b0;
         r_reg_waddr     <= '0;
         r_raddr_index   <= '0;
         r_waddr_index   <= '0;
         r_valid         <= 1'b0;
         r_misalign      <= 1'b0;
         r_misalign_addr <= '0;
         r_misalign_pc   <= '0;
      end else begin
         r_misalign <= 1'b0;
         if (w_act != ACT_HOLD) begin
            r_inst        <= NOP_INST;
            r_inst_addr   <= inst_addr_i;
            r_alu_res     <= '0;
            r_reg_wdata   <= '0;
            r_reg2_rdata  <= '0;
            r_reg_we      <= 1'b0;
            r_reg_waddr   <= '0;
            r_raddr_index <= '0;
            r_waddr_index <= '0;
            r_valid       <= 1'b0;
            if (w_act == ACT_TRAP) begin
               r_misalign      <= 1'b1;
               r_misalign_addr <= alu_res_i;
               r_misalign_pc   <= inst_addr_i;
            end else if (w_act == ACT_CAPTURE && valid_i) begin
               r_inst        <= inst_i;
               r_alu_res     <= alu_res_i;
               r_reg_wdata   <= reg_wdata_i;
               r_reg2_rdata  <= reg2_rdata_i;
               r_reg_we      <= reg_we_i;
               r_reg_waddr   <= reg_waddr_i;
               r_raddr_index <= w_is_load  ? alu_res_i[1:0] : 2'b00;
               r_waddr_index <= w_is_store ? alu_res_i[1:0] : 2'b00;
               r_valid       <= 1'b1;
            end
         end
      end
   end

   assign inst_o            = r_inst;
   assign inst_addr_o       = r_inst_addr;
   assign op1_add_op2_res_o = r_alu_res;
   assign reg_wdata_o       = r_reg_wdata;
   assign reg2_rdata_o      = r_reg2_rdata;
   assign reg_we_o          = r_reg_we;
   assign reg_waddr_o       = r_reg_waddr;
   assign mem_raddr_index_o = r_raddr_index;
   assign mem_waddr_index_o = r_waddr_index;
   assign valid_o           = r_valid;
   assign misalign_o        = r_misalign;
   assign misalign_addr_o   = r_misalign_addr;
   assign misalign_pc_o     = r_misalign_pc;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: queue scoreboard fed by a rule-level reference model.
module tb_ex_mem_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [6:0]  OP_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_STORE = 7'b0100011;
   localparam logic [6:0]  OP_ALU   = 7'b0110011;
   localparam logic [6:0]  OP_ALUI  = 7'b0010011;

   logic        clk = 1'b0;
   logic        rst;
   logic        hold_i, flush_i, valid_i, reg_we_i;
   logic [31:0] inst_i, inst_addr_i, alu_res_i, reg_wdata_i, reg2_rdata_i;
   logic [4:0]  reg_waddr_i;
   logic [31:0] inst_o, inst_addr_o, op1_add_op2_res_o, reg_wdata_o, reg2_rdata_o;
   logic        reg_we_o, valid_o, misalign_o;
   logic [4:0]  reg_waddr_o;
   logic [1:0]  mem_raddr_index_o, mem_waddr_index_o;
   logic [31:0] misalign_addr_o, misalign_pc_o;

   typedef struct {
      logic [31:0] inst, pc, alu, wdata, r2;
      logic        we;
      logic [4:0]  waddr;
      logic        valid, hold, flush;
   } in_t;

   typedef struct {
      logic [31:0] inst, pc, addr, wdata, r2, maddr, mpc;
      logic        we;
      logic [4:0]  waddr;
      logic [1:0]  ridx, widx;
      logic        valid, mis;
   } out_t;

   out_t model;
   out_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   ex_mem_reg #(.NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i), .valid_i(valid_i),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i), .alu_res_i(alu_res_i),
      .reg_wdata_i(reg_wdata_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
      .reg2_rdata_i(reg2_rdata_i), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
      .op1_add_op2_res_o(op1_add_op2_res_o), .reg_wdata_o(reg_wdata_o),
      .reg2_rdata_o(reg2_rdata_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
      .mem_raddr_index_o(mem_raddr_index_o), .mem_waddr_index_o(mem_waddr_index_o),
      .valid_o(valid_o), .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o),
      .misalign_pc_o(misalign_pc_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic out_t reset_state();
      out_t r;
      r.inst = NOP; r.pc = '0; r.addr = '0; r.wdata = '0; r.r2 = '0;
      r.maddr = '0; r.mpc = '0; r.we = 1'b0; r.waddr = '0;
      r.ridx = '0; r.widx = '0; r.valid = 1'b0; r.mis = 1'b0;
      return r;
   endfunction

   // Reference: next visible outputs from the current outputs and this cycle's inputs.
   function automatic out_t model_next(out_t cur, in_t x);
      out_t n;
      logic is_ld, is_st;
      int   width;
      logic bad;
      is_ld = (x.inst[6:0] == OP_LOAD);
      is_st = (x.inst[6:0] == OP_STORE);
      width = 1 << x.inst[13:12];
      bad   = x.valid && (is_ld || is_st) && ((x.alu % width) != 0);
      n = reset_state();
      n.pc    = x.pc;
      n.maddr = cur.maddr;
      n.mpc   = cur.mpc;
      if (x.flush) return n;
      if (x.hold) begin
         n = cur;
         n.mis = 1'b0;
         return n;
      end
      if (bad) begin
         n.mis   = 1'b1;
         n.maddr = x.alu;
         n.mpc   = x.pc;
         return n;
      end
      if (!x.valid) return n;
      n.inst  = x.inst;
      n.addr  = x.alu;
      n.wdata = x.wdata;
      n.r2    = x.r2;
      n.we    = x.we;
      n.waddr = x.waddr;
      n.valid = 1'b1;
      n.ridx  = is_ld ? 2'(x.alu % 4) : 2'd0;
      n.widx  = is_st ? 2'(x.alu % 4) : 2'd0;
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all(input out_t e);
      chk("inst_o",            inst_o,                    e.inst);
      chk("inst_addr_o",       inst_addr_o,               e.pc);
      chk("op1_add_op2_res_o", op1_add_op2_res_o,         e.addr);
      chk("reg_wdata_o",       reg_wdata_o,               e.wdata);
      chk("reg2_rdata_o",      reg2_rdata_o,              e.r2);
      chk("reg_we_o",          32'(reg_we_o),             32'(e.we));
      chk("reg_waddr_o",       32'(reg_waddr_o),          32'(e.waddr));
      chk("mem_raddr_index_o", 32'(mem_raddr_index_o),    32'(e.ridx));
      chk("mem_waddr_index_o", 32'(mem_waddr_index_o),    32'(e.widx));
      chk("valid_o",           32'(valid_o),              32'(e.valid));
      chk("misalign_o",        32'(misalign_o),           32'(e.mis));
      chk("misalign_addr_o",   misalign_addr_o,           e.maddr);
      chk("misalign_pc_o",     misalign_pc_o,             e.mpc);
   endtask

   // Monitor: one output set per clock edge; compare against the oldest expectation.
   initial begin
      out_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp_all(e);
         end
      end
   end

   function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3);
      logic [31:0] r;
      r = $urandom();
      r[14:12] = f3;
      r[6:0]   = op;
      return r;
   endfunction

   task automatic drive(input in_t x);
      @(negedge clk);
      rst          = 1'b0;
      hold_i       = x.hold;
      flush_i      = x.flush;
      valid_i      = x.valid;
      inst_i       = x.inst;
      inst_addr_i  = x.pc;
      alu_res_i    = x.alu;
      reg_wdata_i  = x.wdata;
      reg_we_i     = x.we;
      reg_waddr_i  = x.waddr;
      reg2_rdata_i = x.r2;
      model = model_next(model, x);
      q.push_back(model);
   endtask

   function automatic in_t rand_in();
      in_t   x;
      int    k;
      logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      k = $urandom_range(0, 3);
      case (k)
         0:       x.inst = mk_inst(OP_LOAD,  ld_f3[$urandom_range(0, 4)]);
         1:       x.inst = mk_inst(OP_STORE, 3'($urandom_range(0, 2)));
         2:       x.inst = mk_inst(OP_ALU,   3'($urandom_range(0, 7)));
         default: x.inst = mk_inst(OP_ALUI,  3'($urandom_range(0, 7)));
      endcase
      x.pc    = $urandom() & 32'hFFFF_FFFC;
      x.alu   = $urandom();
      x.wdata = $urandom();
      x.r2    = $urandom();
      x.we    = 1'($urandom_range(0, 1));
      x.waddr = 5'($urandom_range(0, 31));
      x.valid = ($urandom_range(0, 99) < 85);
      x.hold  = ($urandom_range(0, 99) < 15);
      x.flush = ($urandom_range(0, 99) < 10);
      return x;
   endfunction

   function automatic in_t quiet_in(input logic [31:0] inst, input logic [31:0] alu,
                                    input logic [31:0] pc);
      in_t x;
      x = rand_in();
      x.inst = inst; x.alu = alu; x.pc = pc;
      x.valid = 1'b1; x.hold = 1'b0; x.flush = 1'b0;
      return x;
   endfunction

   initial begin
      in_t x;
      int  guard;
      rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; reg_we_i = 1'b0;
      inst_i = '0; inst_addr_i = '0; alu_res_i = '0; reg_wdata_i = '0;
      reg2_rdata_i = '0; reg_waddr_i = '0;
      model = reset_state();
      #3;
      cmp_all(reset_state());
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // aligned LB: read lane 3
      x = quiet_in(mk_inst(OP_LOAD, 3'b000), 32'h0000_1003, 32'h0000_0010);
      x.waddr = 5'd5; x.we = 1'b1;
      drive(x);
      // aligned SH: write lane 2
      x = quiet_in(mk_inst(OP_STORE, 3'b001), 32'h0000_2002, 32'h0000_0014);
      x.r2 = 32'hDEAD_BEEF;
      drive(x);
      // misaligned LW traps, then pulse clears with address retained
      drive(quiet_in(mk_inst(OP_LOAD, 3'b010), 32'h0000_3001, 32'h0000_0040));
      x = quiet_in(mk_inst(OP_ALU, 3'b000), 32'h0000_0000, 32'h0000_0044);
      x.wdata = 32'd7; x.we = 1'b1;
      drive(x);
      // hold three cycles with changing inputs, including a misaligned access
      for (int i = 0; i < 3; i++) begin
         x = rand_in();
         x.hold = 1'b1; x.flush = 1'b0;
         if (i == 1) begin
            x.inst = mk_inst(OP_STORE, 3'b010); x.alu = 32'h0000_5003; x.valid = 1'b1;
         end
         drive(x);
      end
      drive(quiet_in(mk_inst(OP_ALUI, 3'b000), 32'h0000_0123, 32'h0000_0048));
      // flush + hold + misaligned SW: flush wins, no trap
      x = quiet_in(mk_inst(OP_STORE, 3'b010), 32'h0000_6002, 32'h0000_004C);
      x.flush = 1'b1; x.hold = 1'b1;
      drive(x);
      // back-to-back misaligned: LH odd, then LHU odd
      drive(quiet_in(mk_inst(OP_LOAD, 3'b001), 32'h0000_7001, 32'h0000_0050));
      drive(quiet_in(mk_inst(OP_LOAD, 3'b101), 32'h0000_7FFF, 32'h0000_0054));
      // byte store at odd address never traps
      drive(quiet_in(mk_inst(OP_STORE, 3'b000), 32'h0000_8003, 32'h0000_0058));
      // invalid slot with a misaligned word load: bubble, no trap
      x = quiet_in(mk_inst(OP_LOAD, 3'b010), 32'h0000_9002, 32'h0000_005C);
      x.valid = 1'b0;
      drive(x);

      // reset mid-hold: capture, hold, then async reset between edges
      x = quiet_in(mk_inst(OP_ALU, 3'b000), 32'h0000_0001, 32'h0000_0060);
      x.wdata = 32'h1234_5678; x.we = 1'b1;
      drive(x);
      x.hold = 1'b1;
      drive(x);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      model = reset_state();
      cmp_all(model);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 400; i++) drive(rand_in());

      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain actual=%0d pending required=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
